parity_mem: RTL and testbench
=============================

# parity_mem

Parametrised, parity-protected single-port memory. Each write stores `{^data_in, data_in}`. Each read re-checks parity, flags any mismatch and counts errors in a saturating counter. Adds a configurable read latency with a `rd_valid` strobe, per-entry written flags, out-of-range address detection and parity-error injection for test. Sits between the datapath and its storage wherever a byte-wide or wider parity-checked scratch memory is needed.

## Interface
- `DATA_W`, 8: data width in bits; ≥1.
- `ADDR_W`, 16: address port width.
- `DEPTH`, 256: number of entries; 1 ≤ `DEPTH` ≤ 2^`ADDR_W`.
- `READ_LAT`, 1: read latency in cycles; legal values are 1 or 2.
- `ERR_CNT_W`, 8: width of the parity-error counter.

- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `write`, in, 1: write request, sampled on the rising edge.
- `read`, in, 1: read request; ignored when `write`=1.
- `inject_err`, in, 1: qualifies `write`; stores the word with its parity bit inverted.
- `err_clr`, in, 1: synchronous clear of `err_cnt`.
- `data_in`, in, `DATA_W`: write data.
- `address`, in, `ADDR_W`: word address.
- `data_out`, out, `DATA_W+1`: `{parity, data}` of the read word; valid only while `rd_valid`=1.
- `rd_valid`, out, 1: one-cycle strobe marking a read result.
- `par_err`, out, 1: parity mismatch on this result; only ever high together with `rd_valid`.
- `addr_err`, out, 1: one-cycle pulse flagging an access with `address` ≥ `DEPTH`.
- `err_cnt`, out, `ERR_CNT_W`: saturating count of `par_err` events.

## Operation
- **Write** (`write`=1, `address` < `DEPTH`):
  - `mem[address] <= {^data_in ^ inject_err, data_in}`.
  - `written[address] <= 1`.
- **Write priority:** `write` and `read` in the same cycle → the write is performed and the read is dropped. No `rd_valid` results from it.
- **Read** (`read`=1, `write`=0) launches a lookup. The result appears `READ_LAT` cycles later with `rd_valid`=1:
  - In range and written: `data_out = mem[address]`. `par_err = ^data_out` (the stored parity bit XORed with the recomputed data parity).
  - In range, never written since reset: `data_out` = 0, `par_err` = 0.
  - Out of range: `data_out` = 0, `par_err` = 0, `addr_err` = 1 in the same cycle as `rd_valid`.
- **Out-of-range write:** the array is not modified. `addr_err` pulses exactly one cycle after the write is sampled.
- **Back-to-back reads:** one read may be issued every cycle. Results return in issue order, one per cycle.
- **Array storage:** the array holds no reset value. Only the `written` flags and the pipeline state are reset.
- **`err_cnt` update** (`par_err` and `err_clr` both refer to the same cycle):
  - `par_err`=1 → `err_cnt` + 1, saturating at 2^`ERR_CNT_W`−1.
  - `err_clr`=1 and `par_err`=0 → 0.
  - `err_clr`=1 and `par_err`=1 → 1.
- **Reset** (`rst_n`=0, taking effect immediately and asynchronously):
  - `data_out`, `rd_valid`, `par_err`, `addr_err` and `err_cnt` all go to 0.
  - Every `written` flag clears, so the memory is logically empty.
  - In-flight reads are discarded and never produce `rd_valid`.
  - Requests are honoured from the first rising edge after `rst_n` deasserts.

## Timing
- **`READ_LAT`=1:** read sampled at edge N → `rd_valid`, `data_out`, `par_err`, `addr_err` valid after edge N+1.
- **`READ_LAT`=2:** read sampled at edge N → results valid after edge N+2. The internal array output is registered, and the parity check plus result registers form the second stage.
- **Write-to-read:** a write at edge N followed by a read of the same address at edge N+1 returns the new data (no stale read).
- **Output hold:** `data_out` holds its last value when `rd_valid`=0. Consumers must qualify it with `rd_valid`.
- **`err_cnt`** updates on the edge after the cycle in which `par_err` is high.
- **No state machine:** the block is a `READ_LAT`-deep valid/data pipeline plus the counter. There are no stalls or back-pressure.

## Test plan
- **Reset and basic read:**
  - Stimulus: reset, then write 0xA5 @ 0x0010, then read 0x0010 (`READ_LAT`=1).
  - Required: one cycle later `rd_valid`=1, `data_out`=0x0A5, `par_err`=0. Before the first write, all outputs read 0.
- **Uninitialised and out-of-range addresses** (`DEPTH`=256):
  - Stimulus: read unwritten 0x0020, then read 0x0100.
  - Required: both return `data_out`=0 with `par_err`=0; the second also has `addr_err`=1.
  - Stimulus: write to 0x0100.
  - Required: `addr_err` pulses 1 cycle later and a read of 0x0000 is unchanged.
- **Error injection and counter:**
  - Stimulus: write 0x07 @ 0x0003 with `inject_err`=1, then read 0x0003 three times back-to-back.
  - Required: 3 consecutive `rd_valid` cycles, each with `data_out`=0x007 (parity bit 0, since 0x07 has true parity 1) and `par_err`=1; `err_cnt` reaches 3.
  - Stimulus: drive `err_clr` and a `par_err` result in the same cycle.
  - Required: `err_cnt`=1.
- **Saturation** (`ERR_CNT_W`=2):
  - Stimulus: 5 erroneous reads.
  - Required: `err_cnt` sticks at 3.
- **Collision and read-after-write:**
  - Stimulus: `write` and `read` both high for 0x0005 with data 0x3C.
  - Required: no `rd_valid` follows.
  - Stimulus: read 0x0005 on the next cycle.
  - Required: returns 0x03C.
- **Reset mid-operation** (`READ_LAT`=2):
  - Stimulus: issue 2 reads, then assert `rst_n`=0 before the first result.
  - Required: no `rd_valid` appears, `err_cnt`=0, and previously written addresses read 0 after reset.

Source files
------------

// File: rtl/parity_mem.sv
// Parity-protected single-port memory with 1- or 2-cycle read latency,
// per-entry written flags, out-of-range detection and a saturating error counter.
module parity_mem #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned READ_LAT  = 1,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 write,
   input  logic                 read,
   input  logic                 inject_err,
   input  logic                 err_clr,
   input  logic [DATA_W-1:0]    data_in,
   input  logic [ADDR_W-1:0]    address,
   output logic [DATA_W:0]      data_out,
   output logic                 rd_valid,
   output logic                 par_err,
   output logic                 addr_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W:0]      mem [DEPTH];
   logic [DEPTH-1:0]     written_q;
   logic                 in_range;
   logic [IDX_W-1:0]     idx;
   logic                 wr_en;
   logic                 wr_oor;
   logic                 rd_en;
   logic [DATA_W:0]      look_word;

   logic                 fin_v;
   logic                 fin_oor;
   logic [DATA_W:0]      fin_word;

   logic [DATA_W:0]      data_out_q;
   logic                 rd_valid_q;
   logic                 par_err_q;
   logic                 addr_err_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic [ERR_CNT_W-1:0] err_cnt_d;

   assign in_range = {1'b0, address} < DEPTH_LIM;
   assign idx      = address[IDX_W-1:0];
   assign wr_en    = write & in_range;
   assign wr_oor   = write & ~in_range;
   assign rd_en    = read & ~write;

   // Storage has no reset; validity is tracked by written_q instead.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[idx] <= {(^data_in) ^ inject_err, data_in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         written_q <= '0;
      end else if (wr_en) begin
         written_q[idx] <= 1'b1;
      end
   end

   always_comb begin
      look_word = '0;
      if (in_range && written_q[idx]) begin
         look_word = mem[idx];
      end
   end

   if (READ_LAT == 2) begin : g_lat2
      logic            s1_v_q;
      logic            s1_oor_q;
      logic [DATA_W:0] s1_word_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_oor_q  <= 1'b0;
            s1_word_q <= '0;
         end else begin
            s1_v_q   <= rd_en;
            s1_oor_q <= rd_en & ~in_range;
            if (rd_en) begin
               s1_word_q <= look_word;
            end
         end
      end

      assign fin_v    = s1_v_q;
      assign fin_oor  = s1_oor_q;
      assign fin_word = s1_word_q;
   end else begin : g_lat1
      assign fin_v    = rd_en;
      assign fin_oor  = rd_en & ~in_range;
      assign fin_word = look_word;
   end

   // Write-side addr_err is one cycle after the write; read-side aligns with rd_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
         par_err_q  <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         rd_valid_q <= fin_v;
         par_err_q  <= fin_v & (^fin_word);
         addr_err_q <= fin_oor | wr_oor;
         if (fin_v) begin
            data_out_q <= fin_word;
         end
      end
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         err_cnt_d = ERR_CNT_W'(par_err_q);
      end else if (par_err_q && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign data_out = data_out_q;
   assign rd_valid = rd_valid_q;
   assign par_err  = par_err_q;
   assign addr_err = addr_err_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_parity_mem.sv
// Directed bench for parity_mem: a READ_LAT=1 instance with default counter width and a
// READ_LAT=2 instance with a 2-bit counter, both driven by the same stimulus.
module tb_parity_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        write;
   logic        read;
   logic        inject_err;
   logic        err_clr;
   logic [7:0]  data_in;
   logic [15:0] address;

   logic [8:0]  o1_data;
   logic        o1_rv;
   logic        o1_pe;
   logic        o1_ae;
   logic [7:0]  o1_cnt;
   logic [8:0]  o2_data;
   logic        o2_rv;
   logic        o2_pe;
   logic        o2_ae;
   logic [1:0]  o2_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   parity_mem u_lat1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .write      (write),
      .read       (read),
      .inject_err (inject_err),
      .err_clr    (err_clr),
      .data_in    (data_in),
      .address    (address),
      .data_out   (o1_data),
      .rd_valid   (o1_rv),
      .par_err    (o1_pe),
      .addr_err   (o1_ae),
      .err_cnt    (o1_cnt)
   );

   parity_mem #(
      .READ_LAT  (2),
      .ERR_CNT_W (2)
   ) u_lat2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .write      (write),
      .read       (read),
      .inject_err (inject_err),
      .err_clr    (err_clr),
      .data_in    (data_in),
      .address    (address),
      .data_out   (o2_data),
      .rd_valid   (o2_rv),
      .par_err    (o2_pe),
      .addr_err   (o2_ae),
      .err_cnt    (o2_cnt)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      write      = 1'b0;
      read       = 1'b0;
      inject_err = 1'b0;
      err_clr    = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic inj);
      write      = 1'b1;
      address    = a;
      data_in    = d;
      inject_err = inj;
      cyc();
      idle();
   endtask

   // Single isolated read: lat1 result after one edge, lat2 result after the next.
   task automatic do_read(input string tag, input logic [15:0] a, input logic [8:0] ed,
                          input logic epe, input logic eae);
      read    = 1'b1;
      address = a;
      cyc();
      idle();
      check({tag, ".l1_valid"}, 32'(o1_rv), 32'd1);
      check({tag, ".l1_data"}, 32'(o1_data), 32'(ed));
      check({tag, ".l1_par_err"}, 32'(o1_pe), 32'(epe));
      check({tag, ".l1_addr_err"}, 32'(o1_ae), 32'(eae));
      check({tag, ".l2_early"}, 32'(o2_rv), 32'd0);
      cyc();
      check({tag, ".l1_done"}, 32'(o1_rv), 32'd0);
      check({tag, ".l2_valid"}, 32'(o2_rv), 32'd1);
      check({tag, ".l2_data"}, 32'(o2_data), 32'(ed));
      check({tag, ".l2_par_err"}, 32'(o2_pe), 32'(epe));
      check({tag, ".l2_addr_err"}, 32'(o2_ae), 32'(eae));
   endtask

   initial begin
      idle();
      rst_n   = 1'b0;
      address = '0;
      data_in = '0;
      #1;
      check("rst.l1_valid", 32'(o1_rv), 32'd0);
      check("rst.l1_data", 32'(o1_data), 32'd0);
      check("rst.l1_cnt", 32'(o1_cnt), 32'd0);
      check("rst.l2_valid", 32'(o2_rv), 32'd0);
      check("rst.l2_cnt", 32'(o2_cnt), 32'd0);
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
      check("idle.l1_valid", 32'(o1_rv), 32'd0);
      check("idle.l1_addr_err", 32'(o1_ae), 32'd0);
      check("idle.l1_par_err", 32'(o1_pe), 32'd0);

      // Basic writes and reads; 0x11 and 0xA5 both have even parity.
      wr(16'h0000, 8'h11, 1'b0);
      wr(16'h0010, 8'hA5, 1'b0);
      check("wr.l1_addr_err", 32'(o1_ae), 32'd0);
      do_read("basic", 16'h0010, 9'h0A5, 1'b0, 1'b0);
      do_read("addr0", 16'h0000, 9'h011, 1'b0, 1'b0);
      do_read("uninit", 16'h0020, 9'h000, 1'b0, 1'b0);
      do_read("oor_rd", 16'h0100, 9'h000, 1'b0, 1'b1);

      // Out-of-range write: pulse next cycle, no aliasing onto entry 0.
      wr(16'h0100, 8'hFF, 1'b0);
      check("oor_wr.l1_addr_err", 32'(o1_ae), 32'd1);
      check("oor_wr.l2_addr_err", 32'(o2_ae), 32'd1);
      cyc();
      check("oor_wr.l1_pulse_end", 32'(o1_ae), 32'd0);
      do_read("addr0_kept", 16'h0000, 9'h011, 1'b0, 1'b0);
      check("no_err.l1_cnt", 32'(o1_cnt), 32'd0);

      // 0x07 has odd parity; injection stores parity bit 0.
      wr(16'h0003, 8'h07, 1'b1);
      read    = 1'b1;
      address = 16'h0003;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("inj.l1_valid", 32'(o1_rv), 32'd1);
         check("inj.l1_data", 32'(o1_data), 32'h007);
         check("inj.l1_par_err", 32'(o1_pe), 32'd1);
         check("inj.l1_cnt_step", 32'(o1_cnt), 32'(i));
      end
      idle();
      cyc();
      check("inj.l1_valid_end", 32'(o1_rv), 32'd0);
      check("inj.l1_cnt", 32'(o1_cnt), 32'd3);
      check("inj.l2_last", 32'(o2_pe), 32'd1);
      check("inj.l2_cnt", 32'(o2_cnt), 32'd2);

      // err_clr coinciding with par_err on lat1 (-> 1) but not on lat2 (-> 0).
      read    = 1'b1;
      address = 16'h0003;
      cyc();
      check("clr.l1_par_err", 32'(o1_pe), 32'd1);
      check("clr.l2_cnt_pre", 32'(o2_cnt), 32'd3);
      idle();
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      check("clr.l1_cnt", 32'(o1_cnt), 32'd1);
      check("clr.l2_cnt", 32'(o2_cnt), 32'd0);
      check("clr.l2_par_err", 32'(o2_pe), 32'd1);
      cyc();
      check("clr.l2_cnt_after", 32'(o2_cnt), 32'd1);
      check("clr.l1_cnt_after", 32'(o1_cnt), 32'd1);

      // Five more errors: 2-bit counter saturates, 8-bit counter reaches 6.
      read    = 1'b1;
      address = 16'h0003;
      repeat (5) cyc();
      idle();
      repeat (3) cyc();
      check("sat.l2_cnt", 32'(o2_cnt), 32'd3);
      check("sat.l1_cnt", 32'(o1_cnt), 32'd6);

      // Write/read collision drops the read; next-cycle read sees new data.
      write   = 1'b1;
      read    = 1'b1;
      address = 16'h0005;
      data_in = 8'h3C;
      cyc();
      idle();
      check("coll.l1_valid", 32'(o1_rv), 32'd0);
      read    = 1'b1;
      address = 16'h0005;
      cyc();
      idle();
      check("raw.l1_valid", 32'(o1_rv), 32'd1);
      check("raw.l1_data", 32'(o1_data), 32'h03C);
      check("coll.l2_valid", 32'(o2_rv), 32'd0);
      cyc();
      check("raw.l2_valid", 32'(o2_rv), 32'd1);
      check("raw.l2_data", 32'(o2_data), 32'h03C);

      // Asynchronous reset with reads in flight.
      read    = 1'b1;
      address = 16'h0010;
      cyc();
      #3;
      rst_n = 1'b0;
      #1;
      idle();
      check("mid_rst.l1_valid", 32'(o1_rv), 32'd0);
      check("mid_rst.l2_valid", 32'(o2_rv), 32'd0);
      check("mid_rst.l1_cnt", 32'(o1_cnt), 32'd0);
      check("mid_rst.l2_cnt", 32'(o2_cnt), 32'd0);
      check("mid_rst.l2_data", 32'(o2_data), 32'd0);
      repeat (2) cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("post_rst.l2_valid", 32'(o2_rv), 32'd0);
         check("post_rst.l1_valid", 32'(o1_rv), 32'd0);
      end
      do_read("post_rst", 16'h0010, 9'h000, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
